one_wire_slave: RTL and testbench
=================================

ONE_WIRE_SLAVE -- requirements
Module: one_wire_slave

Interface
REQ-001 SHALL have parameter RESET_DETECT, default 20000, minimum dq low cycles that count as a bus reset (400 us at 50 MHz).
REQ-002 SHALL have parameter PRESENCE_WAIT, default 1500, cycles from reset-pulse release to the start of presence drive (30 us).
REQ-003 SHALL have parameter PRESENCE_LOW, default 6000, presence pulse length in cycles (120 us).
REQ-004 SHALL have parameter SAMPLE_POINT, default 1500, cycles from a slot falling edge to the bit sample (30 us).
REQ-005 SHALL have parameter TX0_HOLD, default 1500, cycles dq is held low when transmitting a 0 bit.
REQ-006 SHALL have port clk, input, 1, the single clock of the block; all flops are on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port dq_in, input, 1, the raw 1-wire line level, asynchronous to clk.
REQ-009 SHALL have port dq_oe, output, 1, high to pull the line low; the line is released when it is 0.
REQ-010 SHALL have port rom_id, input, 64, device ID {crc[7:0], serial[47:0], family[7:0]}.
REQ-011 SHALL have port cmd_data, output, 8, the received function command.
REQ-012 SHALL have port cmd_valid, output, 1, one-cycle strobe qualifying cmd_data.
REQ-013 SHALL have port bus_reset, output, 1, one-cycle strobe at each detected reset pulse.
REQ-014 SHALL have port selected, output, 1, high from ROM-phase success until the next reset pulse.

Function
REQ-015 SHALL pass dq_in through a 2-flop synchronizer; all logic SHALL use only the synchronized level dq_s, and falling edges SHALL be detected on dq_s.
REQ-016 SHALL count consecutive dq_s low cycles (saturating, 16 bit); on rising dq_s with count >= RESET_DETECT, SHALL pulse bus_reset, latch rom_id, clear selected, and enter PRES_WAIT from any state.
REQ-017 SHALL run the FSM IDLE, PRES_WAIT, PRES_DRIVE, ROM_RX, MATCH_RX, ID_TX, FUNC_RX, HALT.
REQ-018 PRES_WAIT SHALL last PRESENCE_WAIT cycles, then go to PRES_DRIVE; PRES_DRIVE SHALL assert dq_oe for PRESENCE_LOW cycles, then go to ROM_RX with bit counter 0.
REQ-019 Falling edges SHALL be ignored in IDLE, PRES_WAIT, PRES_DRIVE and HALT, and while a slot is already in progress.
REQ-020 Rx slot: a falling edge SHALL start a slot counter; at SAMPLE_POINT the block SHALL capture dq_s as the bit (1 = released); bits are LSB first.
REQ-021 ROM_RX after 8 bits: 0x55 -> MATCH_RX; 0xCC -> FUNC_RX with selected=1; 0x33 -> ID_TX; any other value -> HALT.
REQ-022 MATCH_RX SHALL compare each sampled bit with latched rom_id[bit]; on a mismatch it SHALL go to HALT immediately; after 64 matches it SHALL set selected and go to FUNC_RX.
REQ-023 ID_TX: on each slot falling edge with latched rom_id[bit]==0, dq_oe SHALL assert for TX0_HOLD cycles; on bit 1, dq_oe SHALL stay 0; the bit counter SHALL advance at SAMPLE_POINT; after bit 63 the FSM SHALL set selected and go to FUNC_RX.
REQ-024 FUNC_RX SHALL receive 8 bits, then drive cmd_data and pulse cmd_valid for exactly 1 cycle, then go to HALT.
REQ-025 HALT SHALL only be left by a reset pulse (REQ-016).
REQ-026 A reset pulse arriving mid-slot or mid-byte SHALL abort the partial byte, clear the counters and force dq_oe=0 first.
REQ-027 The low counter SHALL not increment while dq_oe=1 and the block itself is driving the line.

Reset
REQ-028 On rst_n low: state=IDLE, dq_oe=0, cmd_data=0, cmd_valid=0, bus_reset=0, selected=0, all counters 0, synchronizer flops=1.
REQ-029 After rst_n deasserts, the block SHALL wait in IDLE for a bus reset pulse.

Verification
REQ-030 480 us low then release -> bus_reset pulse; dq_oe high 120 us starting 30 us after release; 300 us low -> no bus_reset.
REQ-031 Reset, 0xCC, 0x44 -> selected=1, cmd_valid 1 cycle with cmd_data=0x44, then HALT.
REQ-032 rom_id=0x A2000000_12345628, reset, 0x55 + matching 64 bits, 0xBE -> cmd_data=0xBE; flip bit 10 -> HALT, no cmd_valid, selected=0.
REQ-033 Reset, 0x33, 64 read slots -> the sampled bits reconstruct rom_id LSB first; 0 bits are low for 30 us.
REQ-034 Unknown ROM cmd 0xF0 -> HALT; a new 480 us reset -> presence and normal operation.
REQ-035 Reset pulse after 4 FUNC_RX bits -> partial byte discarded, presence reissued; async rst_n mid-ID_TX -> dq_oe=0 immediately.

Source files
------------

// File: rtl/one_wire_slave.sv
// one_wire_slave: 1-wire slave handling reset/presence, MATCH/SKIP/READ ROM and one function-command byte.
module one_wire_slave #(
   parameter int RESET_DETECT  = 20000,
   parameter int PRESENCE_WAIT = 1500,
   parameter int PRESENCE_LOW  = 6000,
   parameter int SAMPLE_POINT  = 1500,
   parameter int TX0_HOLD      = 1500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dq_in,
   output logic        dq_oe,
   input  logic [63:0] rom_id,
   output logic [7:0]  cmd_data,
   output logic        cmd_valid,
   output logic        bus_reset,
   output logic        selected
);
   typedef enum logic [2:0] {IDLE, PRES_WAIT, PRES_DRIVE, ROM_RX, MATCH_RX, ID_TX, FUNC_RX, HALT} state_t;
   localparam logic [15:0] RST_MIN = 16'(RESET_DETECT);
   localparam logic [15:0] PW_END  = 16'(PRESENCE_WAIT - 1);
   localparam logic [15:0] PL_END  = 16'(PRESENCE_LOW - 1);
   localparam logic [15:0] SP      = 16'(SAMPLE_POINT);
   localparam logic [15:0] TX0_END = 16'(TX0_HOLD);
   state_t      state, state_nx;
   logic        sync1, dq_s, dq_prev;
   logic [15:0] low_cnt, tmr, tmr_nx;
   logic [5:0]  bit_cnt, bit_nx;
   logic [7:0]  sh, sh_nx, byte_in, cmd_nx;
   logic [63:0] id, id_nx;
   logic        slot_act, slot_nx, oe_nx, cv_nx, br_nx, sel_nx;
   logic        fall, rst_det;
   assign fall    = dq_prev & ~dq_s;
   assign rst_det = ~dq_prev & dq_s & (low_cnt >= RST_MIN);
   assign byte_in = {dq_s, sh[7:1]};
   // Low time is frozen while we pull the line ourselves so presence/TX0 never look like a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         dq_s    <= 1'b1;
         dq_prev <= 1'b1;
         low_cnt <= '0;
      end else begin
         sync1   <= dq_in;
         dq_s    <= sync1;
         dq_prev <= dq_s;
         low_cnt <= dq_s ? '0 : (dq_oe || &low_cnt) ? low_cnt : low_cnt + 16'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tmr       <= '0;
         bit_cnt   <= '0;
         sh        <= '0;
         id        <= '0;
         slot_act  <= 1'b0;
         dq_oe     <= 1'b0;
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
         bus_reset <= 1'b0;
         selected  <= 1'b0;
      end else begin
         state     <= state_nx;
         tmr       <= tmr_nx;
         bit_cnt   <= bit_nx;
         sh        <= sh_nx;
         id        <= id_nx;
         slot_act  <= slot_nx;
         dq_oe     <= oe_nx;
         cmd_data  <= cmd_nx;
         cmd_valid <= cv_nx;
         bus_reset <= br_nx;
         selected  <= sel_nx;
      end
   end
   always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      bit_nx   = bit_cnt;
      sh_nx    = sh;
      id_nx    = id;
      slot_nx  = slot_act;
      oe_nx    = dq_oe;
      cmd_nx   = cmd_data;
      cv_nx    = 1'b0;
      br_nx    = 1'b0;
      sel_nx   = selected;
      if (rst_det) begin
         state_nx = PRES_WAIT;
         tmr_nx   = '0;
         bit_nx   = '0;
         sh_nx    = '0;
         slot_nx  = 1'b0;
         oe_nx    = 1'b0;
         br_nx    = 1'b1;
         sel_nx   = 1'b0;
         id_nx    = rom_id;
      end else begin
         case (state)
            PRES_WAIT: begin
               tmr_nx = tmr + 16'd1;
               if (tmr == PW_END) begin
                  state_nx = PRES_DRIVE;
                  tmr_nx   = '0;
                  oe_nx    = 1'b1;
               end
            end
            PRES_DRIVE: begin
               tmr_nx = tmr + 16'd1;
               if (tmr == PL_END) begin
                  state_nx = ROM_RX;
                  tmr_nx   = '0;
                  oe_nx    = 1'b0;
                  bit_nx   = '0;
                  sh_nx    = '0;
               end
            end
            ROM_RX, MATCH_RX, ID_TX, FUNC_RX: begin
               if (!slot_act) begin
                  if (fall) begin
                     slot_nx = 1'b1;
                     tmr_nx  = 16'd1;
                     oe_nx   = (state == ID_TX) && !id[bit_cnt];
                  end
               end else begin
                  tmr_nx = tmr + 16'd1;
                  if (tmr == TX0_END) oe_nx = 1'b0;
                  // A slot stays open until both the sample and any TX0 drive are done.
                  if (tmr >= SP && tmr >= TX0_END) slot_nx = 1'b0;
                  if (tmr == SP) begin
                     bit_nx = bit_cnt + 6'd1;
                     sh_nx  = byte_in;
                     case (state)
                        ROM_RX: begin
                           if (bit_cnt == 6'd7) begin
                              bit_nx = '0;
                              if (byte_in == 8'h55) state_nx = MATCH_RX;
                              else if (byte_in == 8'hCC) begin
                                 state_nx = FUNC_RX;
                                 sel_nx   = 1'b1;
                              end
                              else if (byte_in == 8'h33) state_nx = ID_TX;
                              else state_nx = HALT;
                           end
                        end
                        MATCH_RX: begin
                           if (dq_s != id[bit_cnt]) state_nx = HALT;
                           else if (&bit_cnt) begin
                              state_nx = FUNC_RX;
                              sel_nx   = 1'b1;
                           end
                        end
                        ID_TX: begin
                           if (&bit_cnt) begin
                              state_nx = FUNC_RX;
                              sel_nx   = 1'b1;
                           end
                        end
                        default: begin
                           if (bit_cnt == 6'd7) begin
                              cmd_nx   = byte_in;
                              cv_nx    = 1'b1;
                              state_nx = HALT;
                           end
                        end
                     endcase
                  end
               end
            end
            default: begin
               slot_nx = 1'b0;
               oe_nx   = 1'b0;
               tmr_nx  = '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_one_wire_slave.sv
// tb_one_wire_slave: randomized 1-wire master against a transaction-level model of the slave.
module tb_one_wire_slave;
   localparam int RD = 200, PW = 15, PL = 60, SP = 15, TH = 15, SLOT = 40;
   logic        clk = 1'b0, rst_n = 1'b0, m_low = 1'b0;
   logic        dq_in, dq_oe, cmd_valid, bus_reset, selected;
   logic [63:0] rom_id = 64'h0123456789ABCDEF;
   logic [7:0]  cmd_data;
   int          checks = 0, errors = 0, br_cnt = 0;
   logic [63:0] m_id = '0, last_read = '0;
   logic        exp_sel = 1'b0, quiet = 1'b0, oe_ok = 1'b0, br_ok = 1'b0;
   logic [7:0]  exp_cmd[$];
   assign dq_in = ~(m_low | dq_oe);
   always #5 clk = ~clk;
   one_wire_slave #(.RESET_DETECT(RD), .PRESENCE_WAIT(PW), .PRESENCE_LOW(PL),
                    .SAMPLE_POINT(SP), .TX0_HOLD(TH)) dut (
      .clk(clk), .rst_n(rst_n), .dq_in(dq_in), .dq_oe(dq_oe), .rom_id(rom_id),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .bus_reset(bus_reset), .selected(selected)
   );
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_reset) br_cnt++;
         if (!oe_ok) check("dq_oe_unexpected", 64'(dq_oe), 64'd0);
         if (!br_ok) check("bus_reset_unexpected", 64'(bus_reset), 64'd0);
         if (quiet) check("selected", 64'(selected), 64'(exp_sel));
         if (cmd_valid) begin
            if (exp_cmd.size() == 0) check("cmd_valid_unexpected", 64'(cmd_valid), 64'd0);
            else check("cmd_data", 64'(cmd_data), 64'(exp_cmd.pop_front()));
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic idle();
      quiet = 1'b1;
      cyc(5);
   endtask
   task automatic bus_rst(input int n, input bit det);
      int t;
      int b0;
      quiet = 1'b0;
      br_ok = 1'b1;
      b0 = br_cnt;
      m_low = 1'b1;
      cyc(n);
      m_low = 1'b0;
      if (!det) begin
         cyc(20);
         check("no_bus_reset", 64'(br_cnt - b0), 64'd0);
      end else begin
         oe_ok = 1'b1;
         t = 0;
         while (!bus_reset && t < 10) begin
            @(negedge clk);
            t++;
         end
         check("bus_reset_latency_ok", 64'(t >= 2 && t <= 5), 64'd1);
         t = 0;
         while (!dq_oe && t < PW + 20) begin
            @(negedge clk);
            t++;
         end
         check("presence_wait", 64'(t), 64'(PW));
         t = 0;
         while (dq_oe && t < PL + 20) begin
            @(negedge clk);
            t++;
         end
         check("presence_len", 64'(t), 64'(PL));
         check("bus_reset_pulses", 64'(br_cnt - b0), 64'd1);
         m_id = rom_id;
         exp_sel = 1'b0;
         oe_ok = 1'b0;
      end
      br_ok = 1'b0;
      cyc(5);
      idle();
   endtask
   task automatic wbit(input bit b);
      quiet = 1'b0;
      m_low = 1'b1;
      cyc(b ? 4 : 30);
      m_low = 1'b0;
      cyc(b ? SLOT - 4 : SLOT - 30);
   endtask
   task automatic wbyte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) wbit(v[i]);
   endtask
   task automatic rbit(output bit b, output int lowlen);
      quiet = 1'b0;
      m_low = 1'b1;
      cyc(6);
      m_low = 1'b0;
      cyc(4);
      b = dq_in;
      lowlen = 10;
      while (!dq_in && lowlen < SLOT - 5) begin
         cyc(1);
         lowlen++;
      end
      cyc(SLOT - lowlen);
   endtask
   task automatic finish_sc();
      idle();
      check("cmd_pending", 64'(exp_cmd.size()), 64'd0);
   endtask
   task automatic sc_skip(input logic [7:0] c);
      wbyte(8'hCC);
      exp_sel = 1'b1;
      idle();
      exp_cmd.push_back(c);
      wbyte(c);
      finish_sc();
      wbyte(8'($urandom));
      finish_sc();
   endtask
   task automatic sc_match(input logic [7:0] c, input int flip);
      wbyte(8'h55);
      for (int i = 0; i < 64; i++) wbit(m_id[i] ^ (i == flip));
      if (flip < 0) begin
         exp_sel = 1'b1;
         exp_cmd.push_back(c);
      end
      idle();
      wbyte(c);
      finish_sc();
   endtask
   task automatic sc_read(input logic [7:0] c);
      bit b;
      int len;
      wbyte(8'h33);
      oe_ok = 1'b1;
      for (int i = 0; i < 64; i++) begin
         rbit(b, len);
         last_read[i] = b;
         if (!m_id[i]) check("tx0_low_len_ok", 64'(len >= TH + 2 && len <= TH + 4), 64'd1);
      end
      oe_ok = 1'b0;
      check("read_id", last_read, m_id);
      exp_sel = 1'b1;
      idle();
      exp_cmd.push_back(c);
      wbyte(c);
      finish_sc();
   endtask
   task automatic sc_unknown(input logic [7:0] v);
      wbyte(v);
      finish_sc();
      wbyte(8'($urandom));
      finish_sc();
   endtask
   task automatic sc_abort(input int k, input logic [7:0] c);
      wbyte(8'hCC);
      exp_sel = 1'b1;
      idle();
      for (int i = 0; i < k; i++) wbit(1'($urandom));
      bus_rst(RD + 40, 1'b1);
      wbyte(8'hCC);
      exp_sel = 1'b1;
      idle();
      exp_cmd.push_back(c);
      wbyte(c);
      finish_sc();
   endtask
   initial begin
      int t;
      logic [7:0] v;
      cyc(3);
      check("rst_dq_oe", 64'(dq_oe), 64'd0);
      check("rst_cmd_data", 64'(cmd_data), 64'd0);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_bus_reset", 64'(bus_reset), 64'd0);
      check("rst_selected", 64'(selected), 64'd0);
      rst_n = 1'b1;
      cyc(5);
      idle();
      bus_rst(150, 1'b0);
      bus_rst(RD - 1, 1'b0);
      bus_rst(RD, 1'b1);
      sc_skip(8'h44);
      rom_id = 64'hA2000000_12345628;
      bus_rst(300, 1'b1);
      check("model_id_latch", m_id, 64'hA2000000_12345628);
      sc_match(8'hBE, -1);
      bus_rst(300, 1'b1);
      sc_match(8'hBE, 10);
      bus_rst(300, 1'b1);
      sc_read(8'h3C);
      check("read_literal", last_read, 64'hA2000000_12345628);
      bus_rst(300, 1'b1);
      sc_unknown(8'hF0);
      bus_rst(300, 1'b1);
      sc_abort(4, 8'h96);
      bus_rst(300, 1'b1);
      wbyte(8'h33);
      quiet = 1'b0;
      oe_ok = 1'b1;
      m_low = 1'b1;
      t = 0;
      while (!dq_oe && t < 10) begin
         cyc(1);
         t++;
      end
      check("tx0_started", 64'(dq_oe), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_dq_oe", 64'(dq_oe), 64'd0);
      check("async_selected", 64'(selected), 64'd0);
      check("async_cmd_valid", 64'(cmd_valid), 64'd0);
      m_low = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      oe_ok = 1'b0;
      exp_sel = 1'b0;
      idle();
      bus_rst(300, 1'b1);
      sc_skip(8'h5A);
      for (int it = 0; it < 6; it++) begin
         rom_id = {$urandom, $urandom};
         bus_rst(RD + int'($urandom_range(0, 100)), 1'b1);
         rom_id = {$urandom, $urandom};
         v = 8'($urandom);
         case ($urandom_range(0, 5))
            0: sc_skip(v);
            1: sc_match(v, -1);
            2: sc_match(v, int'($urandom_range(0, 63)));
            3: sc_read(v);
            4: begin
               do v = 8'($urandom); while (v == 8'h55 || v == 8'hCC || v == 8'h33);
               sc_unknown(v);
            end
            default: sc_abort(int'($urandom_range(1, 6)), v);
         endcase
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
